atm_txn_scheduler: RTL and testbench
====================================

// Module: atm_txn_scheduler
// PURPOSE
//  Shares one account-balance memory among N_TERM ATM front-ends.
//  - Round-robin grant to one requester at a time.
//  - Sequences a fixed read-modify-write per transaction: balance, withdraw, deposit or transfer.
//  - Returns pass/fail and the post-op source balance.
//  - Sits between the terminal FSMs and the balance RAM. Authentication is done upstream.
// PARAMETERS
//  N_TERM  4   number of requesting terminals (2..8)
//  IDX_W   4   account index width (10 accounts used, 16 addressable)
//  BAL_W   16  balance width, unsigned
// PORTS
//  clk        in   1              system clock, all logic on posedge
//  rst        in   1              synchronous, active-high reset
//  req        in   N_TERM         per-terminal request level
//  op         in   2*N_TERM       per terminal: 00 BALANCE, 01 WITHDRAW, 10 DEPOSIT, 11 TRANSFER
//  src_idx    in   IDX_W*N_TERM   per-terminal source account index
//  dst_idx    in   IDX_W*N_TERM   per-terminal destination index (TRANSFER only)
//  amount     in   BAL_W*N_TERM   per-terminal amount
//  gnt        out  N_TERM         one-hot grant, held for the whole transaction
//  done       out  1              1-cycle pulse, transaction finished
//  ok         out  1              valid with done: 1 = op applied
//  bal_out    out  BAL_W          valid with done: source balance after op
//  mem_addr   out  IDX_W          RAM address
//  mem_wdata  out  BAL_W          RAM write data
//  mem_we     out  1              RAM write enable
//  mem_rdata  in   BAL_W          RAM read data, valid the cycle after mem_addr
//  txn_count  out  16             successful-transaction count (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: gnt=0, done=0, ok=0, bal_out=0, mem_we=0, mem_addr=0, mem_wdata=0, txn_count=0.
//    Reset also sets the RR pointer to 0 and the FSM to IDLE.
//  FSM states: IDLE > RD_SRC > RD_DST > CHECK > WR_SRC > WR_DST > DONE > IDLE.
//    The path is fixed for every op, so latency is always 6 cycles.
//  IDLE: if any req is set, pick the first requester at or after the pointer (wrapping).
//    - Set gnt to that requester and latch its op, src, dst and amount.
//    - Set pointer = winner + 1 (mod N_TERM).
//  Latency: done is asserted in the 6th cycle after the cycle gnt first goes high.
//    gnt drops at the same edge done drops. Earliest next grant is the cycle after DONE.
//  RD_SRC: mem_addr = src.
//  RD_DST: capture src balance from mem_rdata; mem_addr = dst.
//  CHECK: capture dst balance, then evaluate ok:
//    - BALANCE: always 1.
//    - WITHDRAW: amount <= src.
//    - DEPOSIT: src + amount <= 2^BAL_W - 1 (compute at BAL_W+1 bits, no wrap).
//    - TRANSFER: amount <= src, dst + amount <= 2^BAL_W - 1, and dst != src.
//  WR_SRC: mem_we=1 only if ok and op != BALANCE.
//    mem_wdata = src - amount (WITHDRAW/TRANSFER) or src + amount (DEPOSIT).
//  WR_DST: mem_we=1 only if ok and op == TRANSFER; mem_wdata = dst + amount.
//  DONE: done=1, ok, bal_out = new src balance (unchanged src on fail).
//  Latched operands are used throughout.
//    Changes to req, op or amount while granted are ignored.
//    Dropping req mid-transaction does not abort it.
//  No writes occur on failure.
//  Reset mid-transaction: FSM to IDLE next edge, mem_we=0, no partial write issued after reset.
//  All req low: stay IDLE, gnt=0, RAM idle (mem_we=0).
// CONFIGURATION
//  ATM_TXN_COUNT_EN defined: txn_count increments on every done with ok=1.
//    It saturates at 16'hFFFF and is cleared by rst.
//  ATM_TXN_COUNT_EN undefined: txn_count is tied to 0 and the counter is not built.
// TESTING
//  1. Single withdraw: RAM[3]=500, T0 WITHDRAW src=3 amt=200.
//     Expect done 6 cycles after gnt=0001, ok=1, bal_out=300, RAM[3]=300.
//  2. Overdraw: RAM[3]=300, WITHDRAW amt=301.
//     Expect ok=0, bal_out=300, no mem_we pulse.
//  3. Transfer: RAM[1]=500, RAM[2]=500, TRANSFER src=1 dst=2 amt=150.
//     Expect ok=1, bal_out=350, RAM[2]=650, two write cycles.
//  4. Round robin: req=1111 held continuously.
//     Expect grant order T0,T1,T2,T3,T0; one transaction at a time; no gnt overlap.
//  5. Deposit overflow: BAL_W=16, RAM[5]=65500, DEPOSIT amt=100.
//     Expect ok=0, RAM[5] unchanged. Transfer with dst=src also gives ok=0.
//  6. Reset in RD_DST: next cycle gnt=0, done never pulses, RAM unchanged, next grant goes to T0.
//     Also check txn_count increments only with the macro defined.

Source files
------------

// File: rtl/atm_txn_scheduler.sv
// Round-robin arbiter and fixed read-modify-write sequencer sharing one balance RAM among ATM terminals.
// Optional successful-transaction counter is built only when ATM_TXN_COUNT_EN is defined.
module atm_txn_scheduler #(
  parameter int N_TERM = 4,
  parameter int IDX_W  = 4,
  parameter int BAL_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_TERM-1:0]       req_i,
  input  logic [2*N_TERM-1:0]     op_i,
  input  logic [IDX_W*N_TERM-1:0] src_idx_i,
  input  logic [IDX_W*N_TERM-1:0] dst_idx_i,
  input  logic [BAL_W*N_TERM-1:0] amount_i,
  output logic [N_TERM-1:0]       gnt_o,
  output logic                    done_o,
  output logic                    ok_o,
  output logic [BAL_W-1:0]        bal_out_o,
  output logic [IDX_W-1:0]        mem_addr_o,
  output logic [BAL_W-1:0]        mem_wdata_o,
  output logic                    mem_we_o,
  input  logic [BAL_W-1:0]        mem_rdata_i,
  output logic [15:0]             txn_count_o
);

  localparam int PTR_W = $clog2(N_TERM);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SRC, S_RD_DST, S_CHECK, S_WR_SRC, S_WR_DST, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_BALANCE  = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_DEPOSIT  = 2'b10,
    OP_TRANSFER = 2'b11
  } op_e;

  state_e            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [N_TERM-1:0] gnt_q;
  logic              done_q;
  logic              ok_q;
  logic [BAL_W-1:0]  bal_q;
  logic [IDX_W-1:0]  addr_q;
  logic [BAL_W-1:0]  wdata_q;
  logic              we_q;
  op_e               op_q;
  logic [IDX_W-1:0]  src_q;
  logic [IDX_W-1:0]  dst_q;
  logic [BAL_W-1:0]  amt_q;
  logic [BAL_W-1:0]  src_bal_q;
  logic [BAL_W-1:0]  dst_new_q;

  logic              found_d;
  logic [PTR_W-1:0]  win_d;
  logic [PTR_W-1:0]  ptr_d;
  int                idx;
  logic [N_TERM-1:0] gnt_sel;
  op_e               op_sel;
  logic [IDX_W-1:0]  src_sel;
  logic [IDX_W-1:0]  dst_sel;
  logic [BAL_W-1:0]  amt_sel;

  // Winner is the first requester at or after the pointer, wrapping around.
  // NOTE: every variable gets a default before any branch so always_comb never infers a latch.
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    idx     = 0;
    for (int i = 0; i < N_TERM; i++) begin
      idx = (int'(ptr_q) + i) % N_TERM;
      if (!found_d && req_i[idx[PTR_W-1:0]]) begin
        found_d = 1'b1;
        win_d   = idx[PTR_W-1:0];
      end
    end
    ptr_d = (win_d == PTR_W'(N_TERM - 1)) ? '0 : win_d + PTR_W'(1);
  end

  always_comb begin
    gnt_sel = '0;
    op_sel  = OP_BALANCE;
    src_sel = '0;
    dst_sel = '0;
    amt_sel = '0;
    for (int i = 0; i < N_TERM; i++) begin
      if (win_d == PTR_W'(i)) begin
        gnt_sel[i] = 1'b1;
        op_sel     = op_e'(op_i[2*i +: 2]);
        src_sel    = src_idx_i[IDX_W*i +: IDX_W];
        dst_sel    = dst_idx_i[IDX_W*i +: IDX_W];
        amt_sel    = amount_i[BAL_W*i +: BAL_W];
      end
    end
  end

  // Sums carry one extra bit so an overflow shows up as a set MSB instead of wrapping.
  logic [BAL_W:0]   src_sum;
  logic [BAL_W:0]   dst_sum;
  logic             covers;
  logic             ok_d;
  logic [BAL_W-1:0] new_src;
  logic [BAL_W-1:0] bal_d;

  always_comb begin
    src_sum = {1'b0, src_bal_q} + {1'b0, amt_q};
    dst_sum = {1'b0, mem_rdata_i} + {1'b0, amt_q};
    covers  = (amt_q <= src_bal_q);
    ok_d    = 1'b1;
    new_src = src_bal_q;
    unique case (op_q)
      OP_BALANCE: begin
        ok_d    = 1'b1;
        new_src = src_bal_q;
      end
      OP_WITHDRAW: begin
        ok_d    = covers;
        new_src = src_bal_q - amt_q;
      end
      OP_DEPOSIT: begin
        ok_d    = !src_sum[BAL_W];
        new_src = src_sum[BAL_W-1:0];
      end
      OP_TRANSFER: begin
        ok_d    = covers && !dst_sum[BAL_W] && (dst_q != src_q);
        new_src = src_bal_q - amt_q;
      end
    endcase
    bal_d = ok_d ? new_src : src_bal_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      bal_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      op_q      <= OP_BALANCE;
      src_q     <= '0;
      dst_q     <= '0;
      amt_q     <= '0;
      src_bal_q <= '0;
      dst_new_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          we_q <= 1'b0;
          if (found_d) begin
            gnt_q   <= gnt_sel;
            ptr_q   <= ptr_d;
            op_q    <= op_sel;
            src_q   <= src_sel;
            dst_q   <= dst_sel;
            amt_q   <= amt_sel;
            addr_q  <= src_sel;
            state_q <= S_RD_SRC;
          end
        end
        S_RD_SRC: begin
          addr_q  <= dst_q;
          state_q <= S_RD_DST;
        end
        S_RD_DST: begin
          src_bal_q <= mem_rdata_i;
          state_q   <= S_CHECK;
        end
        S_CHECK: begin
          ok_q      <= ok_d;
          bal_q     <= bal_d;
          dst_new_q <= dst_sum[BAL_W-1:0];
          addr_q    <= src_q;
          wdata_q   <= bal_d;
          we_q      <= ok_d && (op_q != OP_BALANCE);
          state_q   <= S_WR_SRC;
        end
        S_WR_SRC: begin
          addr_q  <= dst_q;
          wdata_q <= dst_new_q;
          we_q    <= ok_q && (op_q == OP_TRANSFER);
          state_q <= S_WR_DST;
        end
        S_WR_DST: begin
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign ok_o        = ok_q;
  assign bal_out_o   = bal_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = we_q;

`ifdef ATM_TXN_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (done_q && ok_q && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign txn_count_o = cnt_q;
`else
  assign txn_count_o = '0;
`endif

endmodule

// File: tb/tb_atm_txn_scheduler.sv
// Scoreboard bench for atm_txn_scheduler: directed transactions against a behavioural balance RAM.
module tb_atm_txn_scheduler;

  localparam int OP_BAL = 0;
  localparam int OP_WD  = 1;
  localparam int OP_DEP = 2;
  localparam int OP_TR  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [15:0] src_idx;
  logic [15:0] dst_idx;
  logic [63:0] amount;
  logic [3:0]  gnt;
  logic        done;
  logic        ok;
  logic [15:0] bal_out;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [15:0] txn_count;

  always #5 clk = ~clk;

  atm_txn_scheduler #(.N_TERM(4), .IDX_W(4), .BAL_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .op_i        (op),
    .src_idx_i   (src_idx),
    .dst_idx_i   (dst_idx),
    .amount_i    (amount),
    .gnt_o       (gnt),
    .done_o      (done),
    .ok_o        (ok),
    .bal_out_o   (bal_out),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_rdata_i (mem_rdata),
    .txn_count_o (txn_count)
  );

  // Balance RAM with one-cycle read latency; the preload port lets the bench set balances.
  logic [15:0] ram [16];
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int          term;
    logic        ok;
    logic [15:0] bal;
    int          writes;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;
  int   gcyc = 0;
  int   wcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, want);
    end
  endtask

  // Monitor: tracks grant length and write pulses, compares each done against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst || gnt == 4'b0) begin
        gcyc = 0;
        wcnt = 0;
      end else begin
        gcyc++;
        if (mem_we) wcnt++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("gnt_at_done", 32'(gnt), 32'(1) << e.term);
          check("ok", 32'(ok), 32'(e.ok));
          check("bal_out", 32'(bal_out), 32'(e.bal));
          check("latency", gcyc, 6);
          check("write_pulses", wcnt, e.writes);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_term(input int t, input int o, input int s, input int d, input int a);
    op[t*2 +: 2]       = o[1:0];
    src_idx[t*4 +: 4]  = s[3:0];
    dst_idx[t*4 +: 4]  = d[3:0];
    amount[t*16 +: 16] = a[15:0];
  endtask

  task automatic expect_txn(input int t, input bit eok, input int ebal, input int ew);
    exp_t x;
    x.term   = t;
    x.ok     = eok;
    x.bal    = ebal[15:0];
    x.writes = ew;
    sb.push_back(x);
    if (eok) exp_cnt++;
  endtask

  task automatic preload(input int a, input int d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a[3:0];
    pre_data = d[15:0];
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // One terminal runs one transaction; after the grant its inputs are scrambled and req dropped.
  task automatic run_txn(input int t, input int o, input int s, input int d, input int a,
                         input bit eok, input int ebal, input int ew);
    int n;
    @(negedge clk);
    set_term(t, o, s, d, a);
    expect_txn(t, eok, ebal, ew);
    req[t] = 1'b1;
    n = 0;
    while (!gnt[t] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!gnt[t]) check("gnt_timeout", 32'd0, 32'd1);
    req[t]             = 1'b0;
    op[t*2 +: 2]       = 2'b10;
    amount[t*16 +: 16] = 16'hFFFF;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_dones(input int k, input int limit);
    int seen;
    int n;
    seen = 0;
    n    = 0;
    while (seen < k && n < limit) begin
      @(negedge clk);
      n++;
      if (done) seen++;
    end
    req = 4'b0;
    check("done_count", seen, k);
  endtask

  task automatic check_count(input string name);
`ifdef ATM_TXN_COUNT_EN
    check(name, 32'(txn_count), exp_cnt);
`else
    check(name, 32'(txn_count), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    op = '0;
    src_idx = '0;
    dst_idx = '0;
    amount = '0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_bal_out", 32'(bal_out), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_txn_count", 32'(txn_count), 32'd0);
    for (int i = 0; i < 16; i++) preload(i, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_we", 32'(mem_we), 32'd0);

    // Withdraw, overdraw, and withdraw to exactly zero.
    preload(3, 500);
    run_txn(0, OP_WD, 3, 0, 200, 1'b1, 300, 1);
    check("ram3_after_withdraw", 32'(ram[3]), 32'd300);
    run_txn(0, OP_WD, 3, 0, 301, 1'b0, 300, 0);
    check("ram3_after_overdraw", 32'(ram[3]), 32'd300);
    run_txn(1, OP_WD, 3, 0, 300, 1'b1, 0, 1);
    check("ram3_after_exact", 32'(ram[3]), 32'd0);

    // Transfer and balance enquiry.
    preload(1, 500);
    preload(2, 500);
    run_txn(1, OP_TR, 1, 2, 150, 1'b1, 350, 2);
    check("ram1_after_transfer", 32'(ram[1]), 32'd350);
    check("ram2_after_transfer", 32'(ram[2]), 32'd650);
    run_txn(2, OP_BAL, 2, 0, 1234, 1'b1, 650, 0);
    check("ram2_after_balance", 32'(ram[2]), 32'd650);

    // Overflow boundaries and self-transfer.
    preload(5, 65500);
    run_txn(2, OP_DEP, 5, 0, 100, 1'b0, 65500, 0);
    check("ram5_after_dep_ovf", 32'(ram[5]), 32'd65500);
    run_txn(3, OP_TR, 5, 5, 10, 1'b0, 65500, 0);
    check("ram5_after_self_tr", 32'(ram[5]), 32'd65500);
    run_txn(3, OP_DEP, 5, 0, 35, 1'b1, 65535, 1);
    check("ram5_after_dep_max", 32'(ram[5]), 32'd65535);
    run_txn(0, OP_TR, 1, 5, 1, 1'b0, 350, 0);
    check("ram1_after_dst_ovf", 32'(ram[1]), 32'd350);
    check("ram5_after_dst_ovf", 32'(ram[5]), 32'd65535);
    repeat (3) @(negedge clk);
    check_count("txn_count_directed");

    // Round robin from a freshly reset pointer with all four requesting.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    set_term(0, OP_BAL, 1, 0, 0);
    set_term(1, OP_BAL, 2, 0, 0);
    set_term(2, OP_BAL, 3, 0, 0);
    set_term(3, OP_BAL, 5, 0, 0);
    expect_txn(0, 1'b1, 350, 0);
    expect_txn(1, 1'b1, 650, 0);
    expect_txn(2, 1'b1, 0, 0);
    expect_txn(3, 1'b1, 65535, 0);
    expect_txn(0, 1'b1, 350, 0);
    req = 4'b1111;
    wait_dones(5, 200);
    repeat (4) @(negedge clk);
    check_count("txn_count_rr");

    // Reset while T0 is in RD_DST: pointer would otherwise favour T1 next.
    @(negedge clk);
    set_term(0, OP_WD, 1, 0, 50);
    req = 4'b0001;
    begin
      int n;
      n = 0;
      while (!gnt[0] && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("abort_gnt_seen", 32'(gnt), 32'd1);
    end
    req = 4'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_gnt_cleared", 32'(gnt), 32'd0);
    check("abort_we_low", 32'(mem_we), 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (8) @(negedge clk);
    check("abort_ram1_unchanged", 32'(ram[1]), 32'd350);
    set_term(0, OP_BAL, 1, 0, 0);
    set_term(1, OP_BAL, 2, 0, 0);
    expect_txn(0, 1'b1, 350, 0);
    expect_txn(1, 1'b1, 650, 0);
    req = 4'b0011;
    wait_dones(2, 100);
    repeat (4) @(negedge clk);
    check_count("txn_count_after_abort");
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
